// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared definitions for the aFIFO write-port arbiter.
//   state_e - controller states (clear sequence, normal run, drain before clear)
//   clog2   - ceiling log2, never less than 1, used to size small counters
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    function automatic int clog2(input int value);
        int r;
        r = 1;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: producer/consumer-side bundle of the write arbiter.
//   Req_in/Data_in/Grant_out       - NUM_REQ producer request/data/grant
//   Fifo_data_out/wen_out/clear_out - aFIFO write and clear pins
//   Fifo_pop_in                     - read-side pop (ReadEn & !Empty)
//   Flush_in/Ready_out/Count_out    - flush request, run status, occupancy
// master: the environment (producers + read side); slave: the arbiter.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_WIDTH    = 65,
    parameter int ADDRESS_WIDTH = 2
);
    logic [NUM_REQ-1:0]            Req_in;
    logic [NUM_REQ*DATA_WIDTH-1:0] Data_in;
    logic [NUM_REQ-1:0]            Grant_out;
    logic [DATA_WIDTH-1:0]         Fifo_data_out;
    logic                          Fifo_wen_out;
    logic                          Fifo_clear_out;
    logic                          Fifo_pop_in;
    logic                          Flush_in;
    logic                          Ready_out;
    logic [ADDRESS_WIDTH:0]        Count_out;

    modport master (
        output Req_in, Data_in, Fifo_pop_in, Flush_in,
        input  Grant_out, Fifo_data_out, Fifo_wen_out, Fifo_clear_out,
               Ready_out, Count_out
    );

    modport slave (
        input  Req_in, Data_in, Fifo_pop_in, Flush_in,
        output Grant_out, Fifo_data_out, Fifo_wen_out, Fifo_clear_out,
               Ready_out, Count_out
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req - request vector; ptr - highest-priority index
//   gnt - one-hot grant; idx - granted index; any - some request granted
// Walking j = 0..NUM_REQ-1 over position (ptr+j) mod NUM_REQ is the
// rotate, taking the first hit is the priority encode, and using the
// unrotated position directly is the rotate-back.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PTR_W-1:0]   idx,
    output logic               any
);
    int pos;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        gnt = '0;
        idx = ptr;
        any = 1'b0;
        pos = 0;
        for (int j = 0; j < NUM_REQ; j++) begin
            pos = j + int'(ptr);
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            if (!any && req[pos]) begin
                any      = 1'b1;
                idx      = PTR_W'(pos);
                gnt[pos] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: shares the write port of one same-clock aFIFO among
// NUM_REQ producers with round-robin arbitration, tracks occupancy
// (aFIFO has no usable full flag) and sequences the FIFO clear at reset
// and after a flush.
//   Clk, Rst_n - clock, synchronous active-low reset
//   bus        - fifo_wr_arbiter_if.slave (requests, FIFO pins, status)
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int DATA_WIDTH    = 65,
    parameter int ADDRESS_WIDTH = 2,
    parameter int FIFO_DEPTH    = 1 << ADDRESS_WIDTH,
    parameter int CLEAR_CYCLES  = 2
) (
    input  logic                Clk,
    input  logic                Rst_n,
    fifo_wr_arbiter_if.slave    bus
);
    localparam int PTR_W = clog2(NUM_REQ);
    localparam int CLR_W = clog2(CLEAR_CYCLES);
    localparam int CW    = ADDRESS_WIDTH + 1;
    localparam logic [CW-1:0] CAP = CW'(FIFO_DEPTH - 1);

    state_e                  state_q, state_d;
    logic [CLR_W-1:0]        clr_cnt_q, clr_cnt_d;
    logic [CW-1:0]           count_q, count_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic                    wen_q, wen_d;
    logic                    clear_q, clear_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;

    logic [NUM_REQ-1:0]      pick_gnt;
    logic [PTR_W-1:0]        pick_idx;
    logic                    pick_any;
    logic                    grant_ok, grant_any, pop_eff;
    logic [NUM_REQ-1:0]      gnt;

    rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick (
        .req (bus.Req_in),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        ptr_d     = ptr_q;
        wen_d     = 1'b0;
        clear_d   = clear_q;
        data_d    = data_q;

        // A pop frees a slot in the same cycle, so a full FIFO can still take a write.
        grant_ok  = (state_q == S_RUN) && !bus.Flush_in &&
                    ((count_q < CAP) || bus.Fifo_pop_in);
        grant_any = grant_ok && pick_any;
        gnt       = grant_ok ? pick_gnt : '0;
        pop_eff   = bus.Fifo_pop_in && (state_q != S_CLEAR);

        if (grant_any) begin
            wen_d  = 1'b1;
            data_d = bus.Data_in[pick_idx*DATA_WIDTH +: DATA_WIDTH];
            ptr_d  = (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
        end

        // Popping an empty count is a protocol error; hold at zero instead of wrapping.
        if (pop_eff && !grant_any && (count_q == '0)) count_d = '0;
        else count_d = count_q + CW'(grant_any) - CW'(pop_eff);

        case (state_q)
            S_CLEAR: begin
                count_d = '0;
                clear_d = 1'b1;
                if (clr_cnt_q == CLR_W'(CLEAR_CYCLES - 1)) begin
                    state_d = S_RUN;
                    clear_d = 1'b0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (bus.Flush_in) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                // Wait for the last in-flight write to land and be read out.
                if ((count_q == '0) && !wen_q) begin
                    state_d   = S_CLEAR;
                    clr_cnt_d = '0;
                    clear_d   = 1'b1;
                end
            end
            default: begin
                state_d   = S_CLEAR;
                clr_cnt_d = '0;
                clear_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!Rst_n) begin
            state_q   <= S_CLEAR;
            clr_cnt_q <= '0;
            count_q   <= '0;
            ptr_q     <= '0;
            wen_q     <= 1'b0;
            clear_q   <= 1'b1;
            // NOTE: the data register is reset so the FIFO data pins are defined from the first cycle.
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            count_q   <= count_d;
            ptr_q     <= ptr_d;
            wen_q     <= wen_d;
            clear_q   <= clear_d;
            data_q    <= data_d;
        end
    end

    assert property (@(posedge Clk) disable iff (!Rst_n)
        !(bus.Fifo_pop_in && (state_q != S_CLEAR) && (count_q == '0)))
        else $warning("fifo_wr_arbiter: Fifo_pop_in while Count_out is 0");

    assign bus.Grant_out      = gnt;
    assign bus.Fifo_data_out  = data_q;
    assign bus.Fifo_wen_out   = wen_q;
    assign bus.Fifo_clear_out = clear_q;
    assign bus.Ready_out      = (state_q == S_RUN);
    assign bus.Count_out      = count_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed scenarios followed by random traffic.
// A reference model (integers and a modulo search) predicts grants and
// occupancy; expected writes go into a queue that a separate monitor
// drains whenever the DUT raises Fifo_wen_out.
module tb_fifo_wr_arbiter;
    localparam int NUM_REQ       = 4;
    localparam int DATA_WIDTH    = 65;
    localparam int ADDRESS_WIDTH = 2;
    localparam int CLEAR_CYCLES  = 2;
    localparam int CAP           = (1 << ADDRESS_WIDTH) - 1;

    typedef struct {
        logic [DATA_WIDTH-1:0] data;
        int                    due;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_en = 1'b0;

    fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH),
                         .ADDRESS_WIDTH(ADDRESS_WIDTH)) bus ();

    fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH),
                      .ADDRESS_WIDTH(ADDRESS_WIDTH),
                      .CLEAR_CYCLES(CLEAR_CYCLES)) dut (
        .Clk   (clk),
        .Rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state (post-edge view after each step).
    int  m_count, m_ptr, m_clear_left, last_k;
    bit  m_drain, m_wen_pending;
    logic [DATA_WIDTH-1:0] data_reg [NUM_REQ];
    wr_t exp_q[$];
    int  exp_count;
    bit  exp_ready, exp_clear;
    logic [DATA_WIDTH-1:0] last_data;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DATA_WIDTH-1:0] rand_data();
        return DATA_WIDTH'({$urandom, $urandom, $urandom});
    endfunction

    task automatic drive(input logic [NUM_REQ-1:0] req, input bit pop, input bit flush);
        bus.Req_in      = req;
        bus.Fifo_pop_in = pop;
        bus.Flush_in    = flush;
        for (int i = 0; i < NUM_REQ; i++)
            bus.Data_in[i*DATA_WIDTH +: DATA_WIDTH] = data_reg[i];
    endtask

    task automatic publish();
        exp_count = m_count;
        exp_clear = (m_clear_left > 0);
        exp_ready = !m_drain && (m_clear_left == 0);
    endtask

    // One clock of stimulus; checks the combinational grant and advances the model.
    task automatic step(input logic [NUM_REQ-1:0] req, input bit pop, input bit flush);
        logic [NUM_REQ-1:0] exp_gnt;
        int k;
        @(negedge clk);
        rst_n = 1'b1;
        drive(req, pop, flush);
        #1;
        k = -1;
        exp_gnt = '0;
        if (m_clear_left > 0) begin
            m_clear_left--;
            m_count = 0;
        end else if (m_drain) begin
            if (m_count == 0 && !m_wen_pending) begin
                m_drain = 1'b0;
                m_clear_left = CLEAR_CYCLES;
            end else if (pop && m_count > 0) begin
                m_count--;
            end
        end else begin
            if (flush) m_drain = 1'b1;
            else if (m_count < CAP || pop) begin
                for (int j = 0; j < NUM_REQ; j++)
                    if (k < 0 && req[(m_ptr + j) % NUM_REQ]) k = (m_ptr + j) % NUM_REQ;
            end
            m_count = m_count + ((k >= 0) ? 1 : 0) - (pop ? 1 : 0);
            if (m_count < 0) m_count = 0;
        end
        if (k >= 0) begin
            exp_gnt[k] = 1'b1;
            exp_q.push_back('{data: data_reg[k], due: cyc + 1});
            data_reg[k] = rand_data();
            m_ptr = (k + 1) % NUM_REQ;
        end
        m_wen_pending = (k >= 0);
        last_k = k;
        check("grant", bus.Grant_out, exp_gnt);
        publish();
    endtask

    task automatic do_reset(input logic [NUM_REQ-1:0] req);
        @(negedge clk);
        rst_n = 1'b0;
        drive(req, 1'b0, 1'b0);
        m_count = 0; m_ptr = 0; m_clear_left = CLEAR_CYCLES;
        m_drain = 1'b0; m_wen_pending = 1'b0; last_k = -1;
        exp_q.delete();
        publish();
        mon_en = 1'b1;
    endtask

    function automatic bit can_pop();
        return m_count > 0;
    endfunction

    // Monitor: registered outputs and the write scoreboard, sampled after each edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (!rst_n) last_data = '0;
                check("count", bus.Count_out, exp_count);
                check("ready", bus.Ready_out, exp_ready);
                check("clear", bus.Fifo_clear_out, exp_clear);
                if (bus.Fifo_wen_out === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_wen", bus.Fifo_wen_out, 1'b0);
                    end else begin
                        wr_t w;
                        w = exp_q.pop_front();
                        check("wen_cycle", cyc, w.due);
                        check("wr_data", bus.Fifo_data_out, w.data);
                        last_data = w.data;
                    end
                end else begin
                    check("wen_low", bus.Fifo_wen_out, (exp_q.size() > 0 && exp_q[0].due <= cyc));
                    if (exp_q.size() > 0 && exp_q[0].due <= cyc) void'(exp_q.pop_front());
                    check("data_hold", bus.Fifo_data_out, last_data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks", n_checks);
        $fatal(1);
    end

    initial begin
        logic [NUM_REQ-1:0] pend;
        for (int i = 0; i < NUM_REQ; i++) data_reg[i] = rand_data();
        drive('0, 1'b0, 1'b0);

        // 1: reset, clear sequence, then idle in run.
        do_reset('0);
        do_reset('0);
        repeat (4) step('0, 1'b0, 1'b0);

        // 2: all requesters, pop whenever something is stored.
        repeat (6) step(4'b1111, can_pop(), 1'b0);
        while (can_pop()) step('0, 1'b1, 1'b0);
        step('0, 1'b0, 1'b0);

        // 3: single requester fills to capacity; a pop admits exactly one more.
        repeat (5) step(4'b0001, 1'b0, 1'b0);
        step(4'b0001, 1'b1, 1'b0);
        step('0, 1'b0, 1'b0);

        // 4: flush at occupancy 2 with pops continuing.
        step('0, 1'b1, 1'b0);
        step(4'b1111, can_pop(), 1'b1);
        repeat (8) step(4'b1111, can_pop(), 1'b0);
        while (can_pop()) step('0, 1'b1, 1'b0);

        // 5: reset mid-stream at occupancy 3.
        repeat (4) step(4'b0001, 1'b0, 1'b0);
        do_reset(4'b0001);
        repeat (4) step('0, 1'b0, 1'b0);

        // 6: sparse request pattern, then a pop against an empty count.
        repeat (3) step(4'b1010, can_pop(), 1'b0);
        while (can_pop()) step('0, 1'b1, 1'b0);
        step('0, 1'b1, 1'b0);
        step('0, 1'b0, 1'b0);

        // Random traffic: requests held until granted, legal pops, rare flushes.
        pend = '0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NUM_REQ; i++)
                if (!pend[i] && ($urandom_range(1, 0) == 1)) pend[i] = 1'b1;
            step(pend, can_pop() && ($urandom_range(2, 0) != 0), $urandom_range(39, 0) == 0);
            if (last_k >= 0) pend[last_k] = 1'b0;
        end
        while (can_pop()) step('0, 1'b1, 1'b0);
        repeat (3) step('0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
